// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: arbitrates one write and one read requester onto a
// single APB master request port, one transfer at a time.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wrValid/wrReady + wrAddr/wrData/wrStrb/wrProt   write request
//   wrRespValid/wrRespErr           write completion pulse
//   rdValid/rdReady + rdAddr/rdProt read request
//   rdRespValid/rdRespErr/rdRespData read completion pulse
//   pselxM..pprotM                  request to the APB master
//   preadyM/pslverrM/prdataM        completion from the APB master
//
// Build option: define APB_TIMEOUT_EN to abort a transfer with an error
// after timeoutCycles BUSY cycles without preadyM.

module apb_req_arbiter #(
    parameter int dataWidth     = 32,
    parameter int addrWidth     = 32,
    parameter int timeoutCycles = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   wrValid,
    output logic                   wrReady,
    input  logic [addrWidth-1:0]   wrAddr,
    input  logic [dataWidth-1:0]   wrData,
    input  logic [dataWidth/8-1:0] wrStrb,
    input  logic [2:0]             wrProt,
    output logic                   wrRespValid,
    output logic                   wrRespErr,

    input  logic                   rdValid,
    output logic                   rdReady,
    input  logic [addrWidth-1:0]   rdAddr,
    input  logic [2:0]             rdProt,
    output logic                   rdRespValid,
    output logic                   rdRespErr,
    output logic [dataWidth-1:0]   rdRespData,

    output logic                   pselxM,
    output logic                   pwriteM,
    output logic [dataWidth/8-1:0] pstrbM,
    output logic [addrWidth-1:0]   paddrM,
    output logic [dataWidth-1:0]   pwdataM,
    output logic [2:0]             pprotM,
    input  logic                   preadyM,
    input  logic                   pslverrM,
    input  logic [dataWidth-1:0]   prdataM
);

    localparam int StrbW = dataWidth / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    // 1 when the write port was served last; reset to 0 so write wins first
    logic                   lastWr_q, lastWr_d;
    logic                   psel_q, psel_d;
    logic                   pwrite_q, pwrite_d;
    logic [StrbW-1:0]       pstrb_q, pstrb_d;
    logic [addrWidth-1:0]   paddr_q, paddr_d;
    logic [dataWidth-1:0]   pwdata_q, pwdata_d;
    logic [2:0]             pprot_q, pprot_d;
    logic                   err_q, err_d;
    logic [dataWidth-1:0]   data_q, data_d;

    logic                   grantWr;
    logic                   grantRd;

`ifdef APB_TIMEOUT_EN
    localparam int CntW = $clog2(timeoutCycles + 1);
    logic [CntW-1:0]        cnt_q, cnt_d;
`endif

    // Grants are combinational in IDLE; on a tie the port not served last wins
    assign grantWr = (state_q == IDLE) && !rst && wrValid &&
                     (!rdValid || !lastWr_q);
    assign grantRd = (state_q == IDLE) && !rst && rdValid && !grantWr;

    assign wrReady     = grantWr;
    assign rdReady     = grantRd;

    assign pselxM      = psel_q;
    assign pwriteM     = pwrite_q;
    assign pstrbM      = pstrb_q;
    assign paddrM      = paddr_q;
    assign pwdataM     = pwdata_q;
    assign pprotM      = pprot_q;

    assign wrRespValid = (state_q == RESP) && pwrite_q;
    assign rdRespValid = (state_q == RESP) && !pwrite_q;
    assign wrRespErr   = wrRespValid && err_q;
    assign rdRespErr   = rdRespValid && err_q;
    assign rdRespData  = rdRespValid ? data_q : '0;

    always_comb begin
        state_d  = state_q;
        lastWr_d = lastWr_q;
        psel_d   = psel_q;
        pwrite_d = pwrite_q;
        pstrb_d  = pstrb_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pprot_d  = pprot_q;
        err_d    = err_q;
        data_d   = data_q;
`ifdef APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grantWr) begin
                    state_d  = BUSY;
                    lastWr_d = 1'b1;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    pstrb_d  = wrStrb;
                    paddr_d  = wrAddr;
                    pwdata_d = wrData;
                    pprot_d  = wrProt;
`ifdef APB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else if (grantRd) begin
                    state_d  = BUSY;
                    lastWr_d = 1'b0;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b0;
                    pstrb_d  = '0;
                    paddr_d  = rdAddr;
                    pwdata_d = '0;
                    pprot_d  = rdProt;
`ifdef APB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            BUSY: begin
                if (preadyM) begin
                    state_d = RESP;
                    psel_d  = 1'b0;
                    err_d   = pslverrM;
                    data_d  = pwrite_q ? '0 : prdataM;
`ifdef APB_TIMEOUT_EN
                end else if (cnt_q == CntW'(timeoutCycles - 1)) begin
                    // this is the timeoutCycles-th stalled cycle: abort
                    state_d = RESP;
                    psel_d  = 1'b0;
                    err_d   = 1'b1;
                    data_d  = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                data_d  = '0;
            end
            default: begin
                state_d = IDLE;
                psel_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lastWr_q <= 1'b0;
            psel_q   <= 1'b0;
            pwrite_q <= 1'b0;
            pstrb_q  <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pprot_q  <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lastWr_q <= lastWr_d;
            psel_q   <= psel_d;
            pwrite_q <= pwrite_d;
            pstrb_q  <= pstrb_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pprot_q  <= pprot_d;
            err_q    <= err_d;
            data_q   <= data_d;
`ifdef APB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed vectors for apb_req_arbiter.
// Inputs change and outputs are sampled just after the falling edge.

module tb_apb_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrValid, wrReady;
    logic [31:0] wrAddr, wrData;
    logic [3:0]  wrStrb;
    logic [2:0]  wrProt;
    logic        wrRespValid, wrRespErr;
    logic        rdValid, rdReady;
    logic [31:0] rdAddr;
    logic [2:0]  rdProt;
    logic        rdRespValid, rdRespErr;
    logic [31:0] rdRespData;
    logic        pselxM, pwriteM;
    logic [3:0]  pstrbM;
    logic [31:0] paddrM, pwdataM;
    logic [2:0]  pprotM;
    logic        preadyM, pslverrM;
    logic [31:0] prdataM;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_req_arbiter #(
        .dataWidth(32),
        .addrWidth(32),
        .timeoutCycles(16)
    ) dut (
        .clk(clk), .rst(rst),
        .wrValid(wrValid), .wrReady(wrReady),
        .wrAddr(wrAddr), .wrData(wrData),
        .wrStrb(wrStrb), .wrProt(wrProt),
        .wrRespValid(wrRespValid), .wrRespErr(wrRespErr),
        .rdValid(rdValid), .rdReady(rdReady),
        .rdAddr(rdAddr), .rdProt(rdProt),
        .rdRespValid(rdRespValid), .rdRespErr(rdRespErr),
        .rdRespData(rdRespData),
        .pselxM(pselxM), .pwriteM(pwriteM), .pstrbM(pstrbM),
        .paddrM(paddrM), .pwdataM(pwdataM), .pprotM(pprotM),
        .preadyM(preadyM), .pslverrM(pslverrM), .prdataM(prdataM)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        wrValid = 1'b0;
        rdValid = 1'b0;
        preadyM = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wrValid = 1'b1;
        rdValid = 1'b0;
        wrAddr = 32'h0; wrData = 32'h0; wrStrb = 4'h0; wrProt = 3'd0;
        rdAddr = 32'h0; rdProt = 3'd0;
        preadyM = 1'b0; pslverrM = 1'b0; prdataM = 32'h0;

        // reset state, request held during reset must not be granted
        cyc(); #1;
        check("rst_wrReady", wrReady, 0);
        check("rst_psel", pselxM, 0);
        check("rst_pwrite", pwriteM, 0);
        check("rst_paddr", paddrM, 0);
        check("rst_wrResp", wrRespValid, 0);
        check("rst_rdResp", rdRespValid, 0);
        check("rst_rdData", rdRespData, 0);
        wrValid = 1'b0;
        rst = 1'b0;

        // single write, preadyM two cycles after pselxM rises
        cyc();
        wrValid = 1'b1; wrAddr = 32'h10; wrData = 32'hA5A5A5A5;
        wrStrb = 4'hF; wrProt = 3'd2;
        #1;
        check("w_ready", wrReady, 1);
        check("w_rdReady", rdReady, 0);
        cyc();
        wrValid = 1'b0; wrAddr = 32'h0; wrData = 32'h0;
        #1;
        check("w_psel", pselxM, 1);
        check("w_pwrite", pwriteM, 1);
        check("w_paddr", paddrM, 32'h10);
        check("w_pwdata", pwdataM, 32'hA5A5A5A5);
        check("w_pstrb", pstrbM, 4'hF);
        check("w_pprot", pprotM, 3'd2);
        check("w_ready_busy", wrReady, 0);
        cyc();
        wrValid = 1'b1;
        preadyM = 1'b1;
        #1;
        check("w_psel_hold", pselxM, 1);
        check("w_paddr_hold", paddrM, 32'h10);
        check("w_no_grant_busy", wrReady, 0);
        cyc();
        wrValid = 1'b0;
        preadyM = 1'b0;
        #1;
        check("w_resp", wrRespValid, 1);
        check("w_err", wrRespErr, 0);
        check("w_rd_resp", rdRespValid, 0);
        check("w_psel_resp", pselxM, 0);
        cyc(); #1;
        check("w_resp_drop", wrRespValid, 0);

        // single read with slave error; payload after capture is ignored
        rdValid = 1'b1; rdAddr = 32'h20; rdProt = 3'd1;
        wrData = 32'h55AA55AA;
        #1;
        check("r_ready", rdReady, 1);
        check("r_wrReady", wrReady, 0);
        cyc();
        rdValid = 1'b0;
        preadyM = 1'b1; prdataM = 32'hDEADBEEF; pslverrM = 1'b1;
        #1;
        check("r_psel", pselxM, 1);
        check("r_pwrite", pwriteM, 0);
        check("r_paddr", paddrM, 32'h20);
        check("r_pstrb", pstrbM, 0);
        check("r_pwdata", pwdataM, 0);
        check("r_pprot", pprotM, 3'd1);
        cyc();
        prdataM = 32'h12345678; pslverrM = 1'b0;
        #1;
        check("r_resp", rdRespValid, 1);
        check("r_data", rdRespData, 32'hDEADBEEF);
        check("r_err", rdRespErr, 1);
        check("r_wr_resp", wrRespValid, 0);
        check("r_psel_resp", pselxM, 0);
        cyc(); #1;
        check("r_resp_drop", rdRespValid, 0);
        check("r_data_zero", rdRespData, 0);
        preadyM = 1'b0;

        // contention after reset: W,R,W,R with one RESP gap each
        do_reset();
        wrValid = 1'b1; rdValid = 1'b1; preadyM = 1'b1;
        wrData = 32'h0; prdataM = 32'h0;
        for (int c = 0; c < 12; c++) begin
            logic expW, expR, expWr, expRr;
            if (c != 0) cyc();
            #1;
            expW  = (c % 3 == 0) && ((c / 3) % 2 == 0);
            expR  = (c % 3 == 0) && ((c / 3) % 2 == 1);
            expWr = (c % 3 == 2) && ((c / 3) % 2 == 0);
            expRr = (c % 3 == 2) && ((c / 3) % 2 == 1);
            check($sformatf("c%0d_wrReady", c), wrReady, expW);
            check($sformatf("c%0d_rdReady", c), rdReady, expR);
            check($sformatf("c%0d_both", c), wrReady & rdReady, 0);
            check($sformatf("c%0d_psel", c), pselxM, (c % 3 == 1));
            check($sformatf("c%0d_wrResp", c), wrRespValid, expWr);
            check($sformatf("c%0d_rdResp", c), rdRespValid, expRr);
        end
        wrValid = 1'b0; rdValid = 1'b0; preadyM = 1'b0;

        // reset mid-BUSY after a write grant; write must win again
        do_reset();
        wrValid = 1'b1; wrAddr = 32'h44;
        #1;
        check("mr_grant", wrReady, 1);
        cyc();
        rst = 1'b1;
        #1;
        check("mr_psel_busy", pselxM, 1);
        check("mr_ready_in_rst", wrReady, 0);
        cyc();
        rst = 1'b0;
        rdValid = 1'b1;
        preadyM = 1'b1;
        #1;
        check("mr_psel_drop", pselxM, 0);
        check("mr_no_wrResp", wrRespValid, 0);
        check("mr_no_rdResp", rdRespValid, 0);
        check("mr_wr_wins", wrReady, 1);
        check("mr_rd_loses", rdReady, 0);
        cyc();
        wrValid = 1'b0; rdValid = 1'b0;
        #1;
        check("mr_psel", pselxM, 1);
        check("mr_pwrite", pwriteM, 1);
        cyc();
        preadyM = 1'b0;
        #1;
        check("mr_resp", wrRespValid, 1);
        cyc();

        // stalled slave: abort with timeout, or wait indefinitely
        rdValid = 1'b1; rdAddr = 32'h80;
        prdataM = 32'hCAFEF00D; pslverrM = 1'b0; preadyM = 1'b0;
        #1;
        check("to_grant", rdReady, 1);
`ifdef APB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            cyc();
            rdValid = 1'b0;
            #1;
            check($sformatf("to_busy%0d", i), pselxM, 1);
            check($sformatf("to_noresp%0d", i), rdRespValid, 0);
        end
        cyc(); #1;
        check("to_resp", rdRespValid, 1);
        check("to_err", rdRespErr, 1);
        check("to_data", rdRespData, 0);
        check("to_psel", pselxM, 0);
`else
        begin
            int stuck = 0;
            int resps = 0;
            for (int i = 0; i < 110; i++) begin
                cyc();
                rdValid = 1'b0;
                #1;
                if (pselxM) stuck++;
                if (rdRespValid) resps++;
            end
            check("nto_busy_cycles", stuck, 110);
            check("nto_resps", resps, 0);
        end
        preadyM = 1'b1;
        cyc();
        preadyM = 1'b0;
        #1;
        check("nto_resp", rdRespValid, 1);
        check("nto_data", rdRespData, 32'hCAFEF00D);
        check("nto_err", rdRespErr, 0);
`endif
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
